// File: rtl/multi_mode_ff_bank_pkg.sv
// Shared encodings for the multi-mode flip-flop bank.
// Holds the mode values, the SR conflict policy values and the conflict resolver.
package multi_mode_ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'd0,
        MODE_T  = 2'd1,
        MODE_SR = 2'd2,
        MODE_JK = 2'd3
    } mode_e;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;

    // Next state for an SR cell whose S and R are both high.
    function automatic logic sr_resolve(input logic q_cur, input int policy);
        logic q_res;
        q_res = q_cur;
        if (policy == POL_SET) begin
            q_res = 1'b1;
        end else if (policy == POL_RST) begin
            q_res = 1'b0;
        end
        return q_res;
    endfunction

endpackage

// File: rtl/multi_mode_ff_bank_if.sv
// Bus bundle of the flip-flop bank: control and data inputs plus all registered outputs.
interface multi_mode_ff_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;
    logic [WIDTH-1:0] chg;
    logic             illegal;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output en, mode, a, b,
        input  q, qb, chg, illegal, illegal_cnt
    );

    modport slave (
        input  en, mode, a, b,
        output q, qb, chg, illegal, illegal_cnt
    );
endinterface

// File: rtl/multi_mode_ff_bank_ff_cell.sv
// One bit of the bank: D/T/SR/JK next-state logic, change flag and SR conflict detect.
module ff_cell
    import multi_mode_ff_bank_pkg::*;
#(
    parameter int SR_POLICY = POL_HOLD
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  mode_e mode,
    input  logic  a,
    input  logic  b,
    output logic  q,
    output logic  chg,
    output logic  conflict
);

    logic q_q;
    logic q_d;
    logic chg_q;
    logic chg_d;

    always_comb begin
        q_d      = q_q;
        conflict = 1'b0;
        if (en) begin
            case (mode)
                MODE_D: q_d = a;
                MODE_T: q_d = q_q ^ a;
                MODE_SR: begin
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11: begin
                            conflict = 1'b1;
                            q_d      = sr_resolve(q_q, SR_POLICY);
                        end
                        default: q_d = q_q;
                    endcase
                end
                MODE_JK: begin
                    // J=K=1 is a defined toggle here, so it never raises a conflict.
                    case ({a, b})
                        2'b01:   q_d = 1'b0;
                        2'b10:   q_d = 1'b1;
                        2'b11:   q_d = ~q_q;
                        default: q_d = q_q;
                    endcase
                end
                default: q_d = q_q;
            endcase
        end
        chg_d = q_d ^ q_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            chg_q <= chg_d;
        end
    end

    assign q   = q_q;
    assign chg = chg_q;

endmodule

// File: rtl/multi_mode_ff_bank.sv
// Bank of WIDTH mode-selectable flip-flops with a registered illegal flag and
// a saturating count of SR-mode conflict edges.
module multi_mode_ff_bank
    import multi_mode_ff_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SR_POLICY = POL_HOLD,
    parameter int CNT_W     = 8
) (
    input logic                clk,
    input logic                rst,
    multi_mode_ff_bank_if.slave bus
);

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] chg_vec;
    logic [WIDTH-1:0] conflict_vec;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(bus.mode);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            ff_cell #(
                .SR_POLICY (SR_POLICY)
            ) u_cell (
                .clk      (clk),
                .rst      (rst),
                .en       (bus.en),
                .mode     (mode_sel),
                .a        (bus.a[gi]),
                .b        (bus.b[gi]),
                .q        (q_vec[gi]),
                .chg      (chg_vec[gi]),
                .conflict (conflict_vec[gi])
            );
        end
    endgenerate

    logic             illegal_q;
    logic             illegal_d;
    logic [CNT_W-1:0] illegal_cnt_q;
    logic [CNT_W-1:0] illegal_cnt_d;

    // Cell conflicts are already gated by en, so one OR gives one event per edge.
    always_comb begin
        illegal_d     = |conflict_vec;
        illegal_cnt_d = illegal_cnt_q;
        if (illegal_d && (illegal_cnt_q != {CNT_W{1'b1}})) begin
            illegal_cnt_d = illegal_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            illegal_q     <= illegal_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    assign bus.q           = q_vec;
    assign bus.qb          = ~q_vec;
    assign bus.chg         = chg_vec;
    assign bus.illegal     = illegal_q;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_multi_mode_ff_bank.sv
// Directed bench: four banks (hold/set/reset policy, and a 2-bit counter) share one stimulus stream.
module tb_multi_mode_ff_bank;
    import multi_mode_ff_bank_pkg::*;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) if0 ();
    multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) if1 ();
    multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(8)) if2 ();
    multi_mode_ff_bank_if #(.WIDTH(8), .CNT_W(2)) if3 ();

    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(POL_HOLD), .CNT_W(8)) u_pol0 (.clk(clk), .rst(rst), .bus(if0.slave));
    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(POL_SET),  .CNT_W(8)) u_pol1 (.clk(clk), .rst(rst), .bus(if1.slave));
    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(POL_RST),  .CNT_W(8)) u_pol2 (.clk(clk), .rst(rst), .bus(if2.slave));
    multi_mode_ff_bank #(.WIDTH(8), .SR_POLICY(POL_HOLD), .CNT_W(2)) u_cnt2 (.clk(clk), .rst(rst), .bus(if3.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic [7:0] av, input logic [7:0] bv);
        rst = r;
        if0.en = e; if0.mode = m; if0.a = av; if0.b = bv;
        if1.en = e; if1.mode = m; if1.a = av; if1.b = bv;
        if2.en = e; if2.mode = m; if2.a = av; if2.b = bv;
        if3.en = e; if3.mode = m; if3.a = av; if3.b = bv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t rst=%b en=%b mode=%0d a=%h b=%h q=%h qb=%h chg=%h illegal=%b cnt=%0d",
                 $time, rst, if0.en, if0.mode, if0.a, if0.b, if0.q, if0.qb, if0.chg,
                 if0.illegal, if0.illegal_cnt);
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, MODE_D, 8'hFF, 8'hFF);
        step();
        checks++; if (if0.q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", if0.q); end
        checks++; if (if0.qb !== 8'hFF) begin errors++; $display("FAIL reset_qb: got %h want FF", if0.qb); end
        checks++; if (if0.chg !== 8'h00) begin errors++; $display("FAIL reset_chg: got %h want 00", if0.chg); end
        checks++; if (if0.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", if0.illegal); end
        checks++; if (if0.illegal_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", if0.illegal_cnt); end
    endtask

    task automatic test_d_mode();
        drive(1'b0, 1'b1, MODE_D, 8'hA5, 8'h00);
        step();
        checks++; if (if0.q !== 8'hA5) begin errors++; $display("FAIL d_q: got %h want A5", if0.q); end
        checks++; if (if0.qb !== 8'h5A) begin errors++; $display("FAIL d_qb: got %h want 5A", if0.qb); end
        checks++; if (if0.chg !== 8'hA5) begin errors++; $display("FAIL d_chg: got %h want A5", if0.chg); end
    endtask

    task automatic test_t_mode();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h0F; exp_q[1] = 8'h00; exp_q[2] = 8'h0F;
        drive(1'b0, 1'b1, MODE_D, 8'h00, 8'h00);
        step();
        checks++; if (if0.chg !== 8'hA5) begin errors++; $display("FAIL t_clear_chg: got %h want A5", if0.chg); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, MODE_T, 8'h0F, 8'hFF);
            step();
            checks++; if (if0.q !== exp_q[i]) begin errors++; $display("FAIL t_q%0d: got %h want %h", i, if0.q, exp_q[i]); end
            checks++; if (if0.chg !== 8'h0F) begin errors++; $display("FAIL t_chg%0d: got %h want 0F", i, if0.chg); end
        end
    endtask

    task automatic test_sr_mode();
        drive(1'b0, 1'b1, MODE_D, 8'h3C, 8'h00);
        step();
        drive(1'b0, 1'b1, MODE_SR, 8'hFF, 8'hFF);
        step();
        checks++; if (if0.q !== 8'h3C) begin errors++; $display("FAIL sr_hold_q: got %h want 3C", if0.q); end
        checks++; if (if0.chg !== 8'h00) begin errors++; $display("FAIL sr_hold_chg: got %h want 00", if0.chg); end
        checks++; if (if0.illegal !== 1'b1) begin errors++; $display("FAIL sr_illegal: got %b want 1", if0.illegal); end
        checks++; if (if0.illegal_cnt !== 8'd1) begin errors++; $display("FAIL sr_cnt: got %0d want 1", if0.illegal_cnt); end
        checks++; if (if1.q !== 8'hFF) begin errors++; $display("FAIL sr_set_all: got %h want FF", if1.q); end
        checks++; if (if2.q !== 8'h00) begin errors++; $display("FAIL sr_rst_all: got %h want 00", if2.q); end
        drive(1'b0, 1'b1, MODE_SR, 8'hF0, 8'h0F);
        step();
        checks++; if (if0.q !== 8'hF0) begin errors++; $display("FAIL sr_setrst_q: got %h want F0", if0.q); end
        checks++; if (if0.illegal !== 1'b0) begin errors++; $display("FAIL sr_noconf_illegal: got %b want 0", if0.illegal); end
        checks++; if (if0.illegal_cnt !== 8'd1) begin errors++; $display("FAIL sr_noconf_cnt: got %0d want 1", if0.illegal_cnt); end
    endtask

    task automatic test_sr_policy();
        drive(1'b1, 1'b0, MODE_D, 8'h00, 8'h00);
        step();
        drive(1'b0, 1'b1, MODE_SR, 8'h01, 8'h01);
        step();
        checks++; if (if0.q !== 8'h00) begin errors++; $display("FAIL pol_hold_q: got %h want 00", if0.q); end
        checks++; if (if1.q !== 8'h01) begin errors++; $display("FAIL pol_set_q: got %h want 01", if1.q); end
        checks++; if (if2.q !== 8'h00) begin errors++; $display("FAIL pol_rst_q: got %h want 00", if2.q); end
        checks++; if (if1.illegal !== 1'b1) begin errors++; $display("FAIL pol_set_illegal: got %b want 1", if1.illegal); end
        checks++; if (if2.illegal !== 1'b1) begin errors++; $display("FAIL pol_rst_illegal: got %b want 1", if2.illegal); end
        checks++; if (if1.chg !== 8'h01) begin errors++; $display("FAIL pol_set_chg: got %h want 01", if1.chg); end
    endtask

    task automatic test_jk_and_hold();
        drive(1'b0, 1'b1, MODE_D, 8'h0F, 8'h00);
        step();
        drive(1'b0, 1'b1, MODE_JK, 8'hFF, 8'hFF);
        step();
        checks++; if (if0.q !== 8'hF0) begin errors++; $display("FAIL jk_toggle_q: got %h want F0", if0.q); end
        checks++; if (if0.chg !== 8'hFF) begin errors++; $display("FAIL jk_toggle_chg: got %h want FF", if0.chg); end
        checks++; if (if0.illegal !== 1'b0) begin errors++; $display("FAIL jk_illegal: got %b want 0", if0.illegal); end
        drive(1'b0, 1'b1, MODE_JK, 8'h0C, 8'hC0);
        step();
        checks++; if (if0.q !== 8'h3C) begin errors++; $display("FAIL jk_setrst_q: got %h want 3C", if0.q); end
        drive(1'b0, 1'b0, MODE_D, 8'h55, 8'h00);
        step();
        drive(1'b0, 1'b0, MODE_T, 8'hAA, 8'hFF);
        step();
        checks++; if (if0.q !== 8'h3C) begin errors++; $display("FAIL hold_q: got %h want 3C", if0.q); end
        checks++; if (if0.chg !== 8'h00) begin errors++; $display("FAIL hold_chg: got %h want 00", if0.chg); end
        drive(1'b0, 1'b0, MODE_SR, 8'hFF, 8'hFF);
        step();
        checks++; if (if0.illegal !== 1'b0) begin errors++; $display("FAIL hold_illegal: got %b want 0", if0.illegal); end
        checks++; if (if0.q !== 8'h3C) begin errors++; $display("FAIL hold_sr_q: got %h want 3C", if0.q); end
    endtask

    task automatic test_back_to_back();
        drive(1'b0, 1'b1, MODE_D, 8'hAA, 8'h00);
        step();
        checks++; if (if0.q !== 8'hAA) begin errors++; $display("FAIL b2b_d: got %h want AA", if0.q); end
        drive(1'b0, 1'b1, MODE_T, 8'hFF, 8'h00);
        step();
        checks++; if (if0.q !== 8'h55) begin errors++; $display("FAIL b2b_t: got %h want 55", if0.q); end
        drive(1'b0, 1'b1, MODE_SR, 8'h0F, 8'hF0);
        step();
        checks++; if (if0.q !== 8'h0F) begin errors++; $display("FAIL b2b_sr: got %h want 0F", if0.q); end
        checks++; if (if0.chg !== 8'h5A) begin errors++; $display("FAIL b2b_sr_chg: got %h want 5A", if0.chg); end
        drive(1'b0, 1'b1, MODE_JK, 8'hF0, 8'h0F);
        step();
        checks++; if (if0.q !== 8'hF0) begin errors++; $display("FAIL b2b_jk: got %h want F0", if0.q); end
    endtask

    task automatic test_counter_sat();
        logic [1:0] exp_cnt [5];
        exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
        drive(1'b1, 1'b1, MODE_D, 8'h00, 8'h00);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, MODE_SR, 8'h81, 8'h81);
            step();
            checks++; if (if3.illegal_cnt !== exp_cnt[i]) begin errors++; $display("FAIL sat_cnt%0d: got %0d want %0d", i, if3.illegal_cnt, exp_cnt[i]); end
        end
        checks++; if (if0.illegal_cnt !== 8'd5) begin errors++; $display("FAIL wide_cnt: got %0d want 5", if0.illegal_cnt); end
        drive(1'b0, 1'b0, MODE_SR, 8'hFF, 8'hFF);
        step();
        checks++; if (if3.illegal_cnt !== 2'd3) begin errors++; $display("FAIL sat_hold_cnt: got %0d want 3", if3.illegal_cnt); end
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b1, MODE_T, 8'hFF, 8'h00);
        step();
        checks++; if (if3.q !== 8'hFF) begin errors++; $display("FAIL mid_pre_q: got %h want FF", if3.q); end
        drive(1'b1, 1'b1, MODE_T, 8'hFF, 8'h00);
        step();
        checks++; if (if3.q !== 8'h00) begin errors++; $display("FAIL mid_rst_q: got %h want 00", if3.q); end
        checks++; if (if3.chg !== 8'h00) begin errors++; $display("FAIL mid_rst_chg: got %h want 00", if3.chg); end
        checks++; if (if3.illegal_cnt !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", if3.illegal_cnt); end
        drive(1'b1, 1'b1, MODE_SR, 8'hFF, 8'hFF);
        step();
        checks++; if (if3.illegal !== 1'b0) begin errors++; $display("FAIL mid_rst_illegal: got %b want 0", if3.illegal); end
        checks++; if (if3.illegal_cnt !== 2'd0) begin errors++; $display("FAIL mid_rst_sr_cnt: got %0d want 0", if3.illegal_cnt); end
        checks++; if (if1.q !== 8'h00) begin errors++; $display("FAIL mid_rst_set_q: got %h want 00", if1.q); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        drive(1'b1, 1'b0, MODE_D, 8'h00, 8'h00);
        @(negedge clk);
        test_reset();
        test_d_mode();
        test_t_mode();
        test_sr_mode();
        test_sr_policy();
        test_jk_and_hold();
        test_back_to_back();
        test_counter_sat();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
